mac_tx_arbiter: RTL and testbench

MAC_TX_ARBITER -- requirements
Module: mac_tx_arbiter

---
 rtl/eth_pkg.sv | 33 +++
 rtl/mac_tx_arbiter.sv | 136 +++++++++++++
 tb/tb_mac_tx_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet TX constants, tuser field layout and the TX arbiter state type.
package eth_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned KEEP_W = 8;
  localparam int unsigned USER_W = 80;

  // tuser = {len[15:0], dst_mac[47:0], ethertype[15:0]}
  localparam int unsigned USER_ETYPE_LSB = 0;
  localparam int unsigned USER_DST_LSB   = 16;
  localparam int unsigned USER_LEN_LSB   = 64;

  localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
  localparam logic [15:0] ETH_TYPE_IP  = 16'h0800;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  function automatic logic [USER_W-1:0] mk_tuser(input logic [15:0] len,
                                                 input logic [47:0] dst,
                                                 input logic [15:0] etype);
    logic [USER_W-1:0] u;
    u = '0;
    u[USER_LEN_LSB +: 16]   = len;
    u[USER_DST_LSB +: 48]   = dst;
    u[USER_ETYPE_LSB +: 16] = etype;
    return u;
  endfunction

endpackage

// File: rtl/mac_tx_arbiter.sv
// Two-source (ARP/IP) frame-atomic AXI-Stream arbiter feeding the MAC TX, with registered output slice.
// Build option: ARB_FIXED_PRIO_EN selects fixed ARP priority instead of round-robin.
module mac_tx_arbiter
  import eth_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] s0_axis_tdata,
  input  logic [USER_W-1:0] s0_axis_tuser,
  input  logic [KEEP_W-1:0] s0_axis_tkeep,
  input  logic              s0_axis_tlast,
  input  logic              s0_axis_tvalid,
  output logic              s0_axis_tready,
  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic [USER_W-1:0] s1_axis_tuser,
  input  logic [KEEP_W-1:0] s1_axis_tkeep,
  input  logic              s1_axis_tlast,
  input  logic              s1_axis_tvalid,
  output logic              s1_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [USER_W-1:0] m_axis_tuser,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              o_active_src,
  output logic              o_busy
);

  arb_state_e        state_q, state_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic [USER_W-1:0] tuser_q, tuser_d;
  logic [KEEP_W-1:0] tkeep_q, tkeep_d;
  logic              tlast_q, tlast_d;
  logic              tvalid_q, tvalid_d;
  logic              busy_q, busy_d;
  logic              src_q, src_d;

  logic out_free_c;
  logic acc0_c, acc1_c;
  logic any_req_c;
  logic win_c;

  // Output slice can take a beat when empty or draining this cycle.
  assign out_free_c     = !tvalid_q || m_axis_tready;
  assign s0_axis_tready = (state_q == ST_GNT0) && out_free_c;
  assign s1_axis_tready = (state_q == ST_GNT1) && out_free_c;
  assign acc0_c         = s0_axis_tready && s0_axis_tvalid;
  assign acc1_c         = s1_axis_tready && s1_axis_tvalid;
  assign any_req_c      = s0_axis_tvalid || s1_axis_tvalid;

`ifdef ARB_FIXED_PRIO_EN
  assign win_c = !s0_axis_tvalid;
`else
  logic last_q, last_d;

  // last_q names the previous winner; on contention the other source wins.
  assign win_c = (s0_axis_tvalid && s1_axis_tvalid) ? !last_q : s1_axis_tvalid;

  always_comb begin
    last_d = last_q;
    if (state_q == ST_IDLE && any_req_c) last_d = win_c;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`endif

  always_comb begin
    state_d  = state_q;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;

    case (state_q)
      ST_IDLE: if (any_req_c) state_d = win_c ? ST_GNT1 : ST_GNT0;
      ST_GNT0: if (acc0_c && s0_axis_tlast) state_d = ST_IDLE;
      ST_GNT1: if (acc1_c && s1_axis_tlast) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (acc0_c) begin
      tdata_d  = s0_axis_tdata;
      tuser_d  = s0_axis_tuser;
      tkeep_d  = s0_axis_tkeep;
      tlast_d  = s0_axis_tlast;
      tvalid_d = 1'b1;
    end else if (acc1_c) begin
      tdata_d  = s1_axis_tdata;
      tuser_d  = s1_axis_tuser;
      tkeep_d  = s1_axis_tkeep;
      tlast_d  = s1_axis_tlast;
      tvalid_d = 1'b1;
    end else if (m_axis_tready) begin
      tvalid_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
    src_d  = (state_d == ST_GNT1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      tdata_q  <= '0;
      tuser_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      src_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
      busy_q   <= busy_d;
      src_q    <= src_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign o_busy        = busy_q;
  assign o_active_src  = src_q;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed bench for mac_tx_arbiter: scoreboarded output beats plus arbitration, stall and reset checks.
module tb_mac_tx_arbiter;
  import eth_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [63:0]       s0_tdata = '0, s1_tdata = '0, m_tdata;
  logic [79:0]       s0_tuser = '0, s1_tuser = '0, m_tuser;
  logic [7:0]        s0_tkeep = '0, s1_tkeep = '0, m_tkeep;
  logic              s0_tlast = 1'b0, s1_tlast = 1'b0, m_tlast;
  logic              s0_tvalid = 1'b0, s1_tvalid = 1'b0, m_tvalid;
  logic              s0_tready, s1_tready;
  logic              m_tready = 1'b1;
  logic              act_src, busy;

  int                total = 0;
  int                bad   = 0;
  int                cyc   = 0;
  bit                sb_en = 1'b1;
  logic [152:0]      sbq[$];
  int                first_acc[2];
  int                last_acc[2];

  mac_tx_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .s0_axis_tdata(s0_tdata), .s0_axis_tuser(s0_tuser), .s0_axis_tkeep(s0_tkeep),
    .s0_axis_tlast(s0_tlast), .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(s0_tready),
    .s1_axis_tdata(s1_tdata), .s1_axis_tuser(s1_tuser), .s1_axis_tkeep(s1_tkeep),
    .s1_axis_tlast(s1_tlast), .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(s1_tready),
    .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tkeep(m_tkeep),
    .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .o_active_src(act_src), .o_busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] bdata(input int src, input int fid, input int b);
    return {4'hA, 4'(src), 8'(fid), 40'h0, 8'(b)};
  endfunction

  task automatic push_frame(input int src, input int fid, input int n,
                            input logic [79:0] u, input logic [7:0] lkeep);
    for (int b = 0; b < n; b++)
      sbq.push_back({bdata(src, fid, b), u, (b == n-1) ? lkeep : 8'hFF, (b == n-1)});
  endtask

  task automatic drive(input int src, input logic v, input logic [63:0] d,
                       input logic [79:0] u, input logic [7:0] k, input logic l);
    if (src == 0) begin
      s0_tvalid = v; s0_tdata = d; s0_tuser = u; s0_tkeep = k; s0_tlast = l;
    end else begin
      s1_tvalid = v; s1_tdata = d; s1_tuser = u; s1_tkeep = k; s1_tlast = l;
    end
  endtask

  // Drives one frame; abort_at >= 0 asserts reset on that beat instead of completing.
  task automatic send_frame(input int src, input int fid, input int n, input logic [79:0] u,
                            input logic [7:0] lkeep, input bit chk_lat, input int abort_at);
    bit got;
    logic [63:0] d;
    @(posedge clk); #1;
    for (int b = 0; b < n; b++) begin
      d = bdata(src, fid, b);
      drive(src, 1'b1, d, u, (b == n-1) ? lkeep : 8'hFF, (b == n-1));
      if (b == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_tvalid", 160'(m_tvalid), 160'(0));
        chk("rst_mid_tlast", 160'(m_tlast), 160'(0));
        chk("rst_mid_payload", 160'({m_tdata, m_tuser, m_tkeep}), 160'(0));
        chk("rst_mid_treadys", 160'({s0_tready, s1_tready}), 160'(0));
        chk("rst_mid_busy_src", 160'({busy, act_src}), 160'(0));
        rst = 1'b0;
        drive(src, 1'b0, '0, '0, '0, 1'b0);
        return;
      end
      got = 1'b0;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if ((src == 0) ? s0_tready : s1_tready) begin got = 1'b1; break; end
      end
      if (!got) begin
        total++; bad++;
        $error("FAIL accept_timeout src=%0d beat=%0d observed=no_ready expected=ready", src, b);
        drive(src, 1'b0, '0, '0, '0, 1'b0);
        return;
      end
      chk("grant_busy_src", 160'({busy, act_src}), 160'({1'b1, 1'(src)}));
      @(posedge clk); #1;
      if (b == 0) first_acc[src] = cyc;
      if (b == n-1) last_acc[src] = cyc;
      if (chk_lat) chk("lat1_beat", 160'({m_tvalid, m_tdata}), 160'({1'b1, d}));
    end
    drive(src, 1'b0, '0, '0, '0, 1'b0);
  endtask

  // Scoreboard: every downstream handshake must match the next expected beat.
  always @(negedge clk) begin
    if (sb_en && !rst && m_tvalid && m_tready) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $error("FAIL sb_extra_beat observed=%0h expected=none", m_tdata);
      end else begin
        chk("sb_beat", 160'({m_tdata, m_tuser, m_tkeep, m_tlast}), 160'(sbq.pop_front()));
      end
    end
  end

  initial begin
    logic [79:0] u_arp, u_ip, u_arp10;
    logic [63:0] held;
    u_arp   = mk_tuser(16'd4, 48'h0000_1122_3344, ETH_TYPE_ARP);
    u_ip    = mk_tuser(16'd3, 48'h02AA_BBCC_DDEE, ETH_TYPE_IP);
    u_arp10 = mk_tuser(16'd10, 48'd0, ETH_TYPE_ARP);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_tvalid_tlast", 160'({m_tvalid, m_tlast}), 160'(0));
    chk("reset_payload", 160'({m_tdata, m_tuser, m_tkeep}), 160'(0));
    chk("reset_treadys", 160'({s0_tready, s1_tready}), 160'(0));
    chk("reset_busy_src", 160'({busy, act_src}), 160'(0));

    // Contention right after reset: ARP wins first.
    push_frame(0, 1, 4, u_arp, 8'hF0);
    push_frame(1, 2, 3, u_ip, 8'hFC);
    fork
      send_frame(0, 1, 4, u_arp, 8'hF0, 1'b0, -1);
      send_frame(1, 2, 3, u_ip, 8'hFC, 1'b0, -1);
    join
    repeat (3) @(posedge clk);

    // ARP-only 10-beat frame, 1-cycle latency.
    push_frame(0, 3, 10, u_arp10, 8'hFE);
    send_frame(0, 3, 10, u_arp10, 8'hFE, 1'b1, -1);
    repeat (3) @(posedge clk);

    // Second contention, last winner was ARP.
`ifdef ARB_FIXED_PRIO_EN
    push_frame(0, 4, 2, u_arp, 8'hFF);
    push_frame(1, 5, 2, u_ip, 8'hFF);
`else
    push_frame(1, 5, 2, u_ip, 8'hFF);
    push_frame(0, 4, 2, u_arp, 8'hFF);
`endif
    fork
      send_frame(0, 4, 2, u_arp, 8'hFF, 1'b0, -1);
      send_frame(1, 5, 2, u_ip, 8'hFF, 1'b0, -1);
    join
`ifdef ARB_FIXED_PRIO_EN
    chk("contention2_order", 160'(first_acc[0] < first_acc[1]), 160'(1));
`else
    chk("contention2_order", 160'(first_acc[1] < first_acc[0]), 160'(1));
`endif
    repeat (3) @(posedge clk);

    // Downstream stall mid-frame: ready 1,0,0,1.
    push_frame(0, 6, 8, u_arp, 8'hC0);
    fork
      send_frame(0, 6, 8, u_arp, 8'hC0, 1'b0, -1);
      begin
        repeat (4) @(posedge clk);
        #1 m_tready = 1'b0;
        @(negedge clk);
        held = m_tdata;
        chk("stall_tvalid", 160'(m_tvalid), 160'(1));
        chk("stall_s0_ready_a", 160'(s0_tready), 160'(0));
        @(negedge clk);
        chk("stall_hold_data", 160'(m_tdata), 160'(held));
        chk("stall_s0_ready_b", 160'(s0_tready), 160'(0));
        @(posedge clk); #1 m_tready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);

    // Single-beat IP frame.
    push_frame(1, 7, 1, u_ip, 8'h80);
    send_frame(1, 7, 1, u_ip, 8'h80, 1'b1, -1);
    chk("single_tlast_keep", 160'({m_tlast, m_tkeep}), 160'({1'b1, 8'h80}));
    chk("single_busy_drop", 160'(busy), 160'(0));
    repeat (3) @(posedge clk);

    // IP request during an ARP frame waits for tlast plus the idle bubble.
    push_frame(0, 8, 5, u_arp, 8'hFF);
    push_frame(1, 9, 3, u_ip, 8'hFE);
    fork
      send_frame(0, 8, 5, u_arp, 8'hFF, 1'b0, -1);
      begin
        repeat (2) @(posedge clk);
        send_frame(1, 9, 3, u_ip, 8'hFE, 1'b0, -1);
      end
    join
    chk("ip_after_arp_bubble", 160'(first_acc[1]), 160'(last_acc[0] + 2));
    repeat (3) @(posedge clk);

    // Reset on beat 4 of 10, then a clean ARP frame.
    sb_en = 1'b0;
    send_frame(0, 10, 10, u_arp10, 8'hFF, 1'b0, 3);
    repeat (2) @(posedge clk);
    sb_en = 1'b1;
    push_frame(0, 11, 4, u_arp, 8'hF8);
    send_frame(0, 11, 4, u_arp, 8'hF8, 1'b1, -1);
    repeat (5) @(posedge clk);
    chk("sb_drained", 160'(sbq.size()), 160'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
